regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the multi-cycle/next-gen datapath: NUM_RD combinational

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, index/word typedefs and zero-register index for regfile_mp
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_IDX   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy flags and reservation-error pulse
// A reservation wins over a same-cycle writeback of the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rsv_err_q, rsv_err_d;
  logic             rsv_written;
  logic             rsv_is_zero;

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (rsv_en && rsv_addr == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((wr0_en && wr0_addr == ADDR_W'(r)) || (wr1_en && wr1_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[ZERO_IDX] = 1'b0;
    end

    // A register being written back this edge is not a genuine double reservation.
    rsv_written = (wr0_en && wr0_addr == rsv_addr) || (wr1_en && wr1_addr == rsv_addr);
    rsv_is_zero = (ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX));
    rsv_err_d   = rsv_en && busy_q[rsv_addr] && !rsv_is_zero && !rsv_written;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign rsv_err  = rsv_err_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports and busy scoreboard
// REGFILE_MP_BYPASS_EN: forward same-cycle write data and busy clears onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_err,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr0_ok, wr1_ok;

  assign wr0_ok = wr0_en && !((ZERO_REG != 0) && wr0_addr == ADDR_W'(ZERO_IDX));
  assign wr1_ok = wr1_en && !((ZERO_REG != 0) && wr1_addr == ADDR_W'(ZERO_IDX));

  // wr1 is assigned last so it wins an index collision with wr0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_ok) mem_q[wr0_addr] <= wr0_data;
      if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_err  (rsv_err),
    .busy_vec (busy_vec)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbsy;
`ifdef REGFILE_MP_BYPASS_EN
    logic wr0_hit, wr1_hit, rsv_hit;
`endif

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = mem_q[ra];
      rbsy = busy_vec[ra];
`ifdef REGFILE_MP_BYPASS_EN
      wr0_hit = wr0_en && (wr0_addr == ra);
      wr1_hit = wr1_en && (wr1_addr == ra);
      rsv_hit = rsv_en && (rsv_addr == ra);
      if (wr1_hit) begin
        rdat = wr1_data;
      end else if (wr0_hit) begin
        rdat = wr0_data;
      end
      if ((wr0_hit || wr1_hit) && !rsv_hit) begin
        rbsy = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && ra == ADDR_W'(ZERO_IDX)) begin
        rdat = '0;
        rbsy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
    assign rd_busy[k]                  = rbsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp (default build plus a 4-port 16x8 build)
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default build: DATA_W 32, ADDR_W 5, NUM_RD 2
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en, wr1_en, rsv_en;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        rsv_err;
  logic [31:0] busy_vec;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err), .busy_vec(busy_vec)
  );

  // small build: DATA_W 16, ADDR_W 3, NUM_RD 4
  logic        s_rst;
  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic        s_wr0_en, s_wr1_en, s_rsv_en;
  logic [2:0]  s_wr0_addr, s_wr1_addr, s_rsv_addr;
  logic [15:0] s_wr0_data, s_wr1_data;
  logic        s_rsv_err;
  logic [7:0]  s_busy_vec;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) dut_s (
    .clk(clk), .rst(s_rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr0_en(s_wr0_en), .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data),
    .wr1_en(s_wr1_en), .wr1_addr(s_wr1_addr), .wr1_data(s_wr1_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .rsv_err(s_rsv_err), .busy_vec(s_busy_vec)
  );

  typedef struct {
    logic        rst;
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        re;  logic [4:0] ra;
    logic [4:0]  a0;  logic [4:0] a1;
    logic [31:0] e0;  logic [31:0] e1;
    logic [1:0]  eb;  logic [31:0] ebv; logic eerr;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    s_rst = 1'b0; s_wr0_en = 1'b0; s_wr1_en = 1'b0; s_rsv_en = 1'b0;
  endtask

  // Clock the edge, then drop all strobes and let the read muxes settle.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctl();
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr0_en = 0; wr1_en = 0; rsv_en = 0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0; wr0_data = '0; wr1_data = '0;
    s_rst = 1'b1; s_rd_addr = '0; s_wr0_en = 0; s_wr1_en = 0; s_rsv_en = 0;
    s_wr0_addr = '0; s_wr1_addr = '0; s_rsv_addr = '0; s_wr0_data = '0; s_wr1_data = '0;

    //            rst w0e w0a  w0d           w1e w1a  w1d           re ra   a0  a1   e0            e1            eb     ebv            eerr
    vecs[0]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0,         0};
    vecs[1]  = '{0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0,         0};
    vecs[2]  = '{0, 1, 5'd7, 32'h11,       1, 5'd7, 32'h22,       0, 5'd0, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 2'b00, 32'h0,         0};
    vecs[3]  = '{0, 0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd7, 32'h0,        32'h22,       2'b00, 32'h0,         0};
    vecs[4]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 5'd7, 32'h0,        32'h22,       2'b01, 32'h200,       0};
    vecs[5]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 5'd7, 32'h0,        32'h22,       2'b01, 32'h200,       1};
    vecs[6]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd7, 32'h0,        32'h22,       2'b01, 32'h200,       0};
    vecs[7]  = '{0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h55,       0, 5'd0, 5'd9, 5'd7, 32'h55,       32'h22,       2'b00, 32'h0,         0};
    vecs[8]  = '{0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h66,       1, 5'd9, 5'd9, 5'd7, 32'h66,       32'h22,       2'b01, 32'h200,       0};
    vecs[9]  = '{0, 1, 5'd9, 32'h77,       0, 5'd0, 32'h0,        1, 5'd9, 5'd9, 5'd7, 32'h77,       32'h22,       2'b01, 32'h200,       0};
    vecs[10] = '{0, 1, 5'd3, 32'hA5A5,     1, 5'd4, 32'h1234,     1, 5'd4, 5'd3, 5'd4, 32'hA5A5,     32'h1234,     2'b10, 32'h210,       0};
    vecs[11] = '{0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h88,       1, 5'd4, 5'd9, 5'd4, 32'h88,       32'h1234,     2'b10, 32'h10,        1};
    vecs[12] = '{1, 1, 5'd4, 32'h9,        0, 5'd0, 32'h0,        1, 5'd4, 5'd3, 5'd4, 32'h0,        32'h0,        2'b00, 32'h0,         0};

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
      wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
      rsv_en = vecs[i].re;  rsv_addr = vecs[i].ra;
      rd_addr = {vecs[i].a1, vecs[i].a0};
      tick();
      check($sformatf("v%0d rd0", i), 64'(rd_data[31:0]), 64'(vecs[i].e0));
      check($sformatf("v%0d rd1", i), 64'(rd_data[63:32]), 64'(vecs[i].e1));
      check($sformatf("v%0d rd_busy", i), 64'(rd_busy), 64'(vecs[i].eb));
      check($sformatf("v%0d busy_vec", i), 64'(busy_vec), 64'(vecs[i].ebv));
      check($sformatf("v%0d rsv_err", i), 64'(rsv_err), 64'(vecs[i].eerr));
    end

    // same-cycle visibility of writes on the read port (bypass build forwards)
    rd_addr = {5'd0, 5'd3};
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h1;
    tick();
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'hA5A5;
    #1;
    check("fwd wr0 same cycle", 64'(rd_data[31:0]), BYP ? 64'hA5A5 : 64'h1);
    tick();
    check("fwd wr0 next cycle", 64'(rd_data[31:0]), 64'hA5A5);
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 5'd3; wr1_data = 32'h2;
    #1;
    check("fwd collision same cycle", 64'(rd_data[31:0]), BYP ? 64'h2 : 64'hA5A5);
    tick();
    check("fwd collision next cycle", 64'(rd_data[31:0]), 64'h2);
    rsv_en = 1; rsv_addr = 5'd3;
    tick();
    wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'h5;
    #1;
    check("fwd busy cleared by write", 64'(rd_busy[0]), BYP ? 64'h0 : 64'h1);
    rsv_en = 1; rsv_addr = 5'd3;
    #1;
    check("fwd busy kept by reserve", 64'(rd_busy[0]), 64'h1);
    tick();
    check("busy after rsv+wr", 64'(busy_vec), 64'h8);

    // small build: 4 read ports, 8 registers of 16 bits
    s_rst = 1'b1;
    tick();
    check("s reset busy_vec", 64'(s_busy_vec), 64'h0);
    s_rd_addr = {3'd0, 3'd7, 3'd0, 3'd5};
    s_wr0_en = 1; s_wr0_addr = 3'd5; s_wr0_data = 16'hBEEF;
    tick();
    check("s p0 r5", 64'(s_rd_data[15:0]), 64'hBEEF);
    check("s p1 r0", 64'(s_rd_data[31:16]), 64'h0);
    s_wr0_en = 1; s_wr0_addr = 3'd7; s_wr0_data = 16'h11;
    s_wr1_en = 1; s_wr1_addr = 3'd7; s_wr1_data = 16'h22;
    tick();
    check("s p2 r7 collision", 64'(s_rd_data[47:32]), 64'h22);
    s_wr1_en = 1; s_wr1_addr = 3'd0; s_wr1_data = 16'hFFFF;
    s_rsv_en = 1; s_rsv_addr = 3'd0;
    tick();
    check("s p1 r0 after write", 64'(s_rd_data[31:16]), 64'h0);
    check("s busy_vec r0", 64'(s_busy_vec), 64'h0);
    check("s rsv_err r0", 64'(s_rsv_err), 64'h0);
    s_rd_addr = {3'd6, 3'd7, 3'd0, 3'd5};
    s_rsv_en = 1; s_rsv_addr = 3'd6;
    tick();
    check("s busy_vec r6", 64'(s_busy_vec), 64'h40);
    check("s p3 busy r6", 64'(s_rd_busy), 64'h8);
    s_rsv_en = 1; s_rsv_addr = 3'd6;
    tick();
    check("s rsv_err double", 64'(s_rsv_err), 64'h1);
    s_wr1_en = 1; s_wr1_addr = 3'd6; s_wr1_data = 16'h55;
    tick();
    check("s p3 r6 data", 64'(s_rd_data[63:48]), 64'h55);
    check("s busy_vec cleared", 64'(s_busy_vec), 64'h0);
    check("s rsv_err dropped", 64'(s_rsv_err), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
